perceptron_stimulus_driver: RTL
===============================

// Module: perceptron_stimulus_driver
// PURPOSE
//  Initiator side of the perceptron feature interface. Accepts a digit (0-9) on a
//  valid/ready request port and drives that digit's canonical feature vector
//  (edge count, curve count) to the classifier. After a settle window it samples
//  the classifier's 4-bit answer, reports match/mismatch and keeps saturating
//  pass/fail tallies. Used as the on-chip self-test front end of the classifier.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles features are held before sampling; legal 1..15
//  CNT_W          8  width of pass/fail counters
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  ena          in   1      1 = run; 0 = freeze FSM/counters, req_ready forced 0
//  req_valid    in   1      digit request valid
//  req_digit    in   4      requested digit
//  req_ready    out  1      1 only in IDLE with ena=1
//  feat_edges   out  3      edge-count feature to classifier
//  feat_curves  out  4      curve-count feature to classifier
//  feat_valid   out  1      features are being driven
//  cls_out      in   4      classifier result (combinational from feat_*)
//  rsp_valid    out  1      one-cycle response pulse
//  rsp_match    out  1      cls_out == requested digit (qualified by rsp_valid)
//  rsp_bad      out  1      request digit > 9 (qualified by rsp_valid)
//  rsp_got      out  4      sampled cls_out (0 when rsp_bad)
//  clear_cnt    in   1      synchronous clear of both counters
//  pass_cnt     out  CNT_W  number of matches, saturates at all-ones
//  fail_cnt     out  CNT_W  number of mismatches, saturates at all-ones
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except req_ready = ena (combinational).
//  - Handshake: transfer when req_valid & req_ready. Request fields ignored otherwise.
//  - States: IDLE -> DRIVE (SETTLE_CYCLES cyc) -> SAMPLE (1) -> REPORT (1) -> IDLE.
//    Bad digit (>9): IDLE -> REPORT directly, no features driven.
//  - Accept at edge T: feat_* registered from FEATURE_LUT, visible from T+1;
//    feat_valid=1 through DRIVE and SAMPLE; cls_out captured at end of SAMPLE;
//    rsp_valid high for cycle T+SETTLE_CYCLES+2; req_ready again at T+SETTLE_CYCLES+3.
//    Bad digit: rsp_valid at cycle T+1, rsp_bad=1, rsp_match=0.
//  - feat_* return to 0 and feat_valid to 0 on leaving SAMPLE.
//  - REPORT: match -> pass_cnt+1, mismatch -> fail_cnt+1, bad -> neither; hold at
//    2^CNT_W-1. rsp_* registered, hold last value when rsp_valid=0.
//  - clear_cnt coincident with increment: clear wins (counter = 0).
//  - ena=0 mid-operation: state, settle counter, feat_*, counters all hold; no
//    rsp_valid pulse while frozen; resumes exactly where it stopped.
//  - rst_n asserted mid-operation: immediate return to reset values, request lost.
//  - FEATURE_LUT {edges,curves}: 0:{0,2} 1:{1,0} 2:{2,1} 3:{0,3} 4:{3,0}
//    5:{2,2} 6:{1,2} 7:{2,0} 8:{0,4} 9:{1,3}.
// STRUCTURE
//  - Package perceptron_pkg: NUM_CLASSES=10, FEATURE_LUT, feature field widths,
//    state enum (IDLE, DRIVE, SAMPLE, REPORT); shared with the classifier.
//  - One sub-module: sat_counter (CNT_W, inc, clr, hold) instanced for pass and fail.
//  - Settle down-counter, FSM and response registers inline.
// TESTING
//  1 Reset with ena=1: all outputs 0, req_ready=1; feature/rsp outputs stay 0 idle.
//  2 Digit 5, cls_out stub returns 5: feat={2,2} from T+1 to T+3, rsp_valid at T+4,
//    rsp_match=1, rsp_got=5, pass_cnt=1, fail_cnt=0.
//  3 Digit 8, stub returns 3: feat={0,4}, rsp_match=0, rsp_got=3, fail_cnt=1.
//  4 Digit 12: no feat_valid, rsp_valid at T+1 with rsp_bad=1, counters unchanged.
//  5 ena low for 5 cycles in DRIVE: feat held, rsp_valid delayed by exactly 5;
//    rst_n pulse in SAMPLE: outputs 0, IDLE, no response.
//  6 256 matching requests with CNT_W=8: pass_cnt saturates at 255; clear_cnt
//    in same cycle as a REPORT -> pass_cnt=0.

Source files
------------

// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared perceptron feature definitions
// Purpose: feature field widths, canonical per-digit feature table and the
//          stimulus driver state encoding, shared with the classifier.
// Ports:   none (package)
package perceptron_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int DIGIT_W     = 4;
  localparam int EDGE_W      = 3;
  localparam int CURVE_W     = 4;

  typedef struct packed {
    logic [EDGE_W-1:0]  edges;
    logic [CURVE_W-1:0] curves;
  } feature_t;

  // Canonical {edges, curves} per digit, index = digit.
  localparam feature_t FEATURE_LUT [NUM_CLASSES] = '{
    '{3'd0, 4'd2},
    '{3'd1, 4'd0},
    '{3'd2, 4'd1},
    '{3'd0, 4'd3},
    '{3'd3, 4'd0},
    '{3'd2, 4'd2},
    '{3'd1, 4'd2},
    '{3'd2, 4'd0},
    '{3'd0, 4'd4},
    '{3'd1, 4'd3}
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_REPORT
  } state_t;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] digit);
    return digit < DIGIT_W'(NUM_CLASSES);
  endfunction

  // Out-of-range digits map to an all-zero feature so the table is never
  // indexed past its end.
  function automatic feature_t feature_of(input logic [DIGIT_W-1:0] digit);
    feature_t f;
    f = '0;
    if (digit_ok(digit)) begin
      f = FEATURE_LUT[digit];
    end
    return f;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with clear and hold
// Purpose: counts inc pulses, sticks at all-ones; clr has priority over
//          everything else, hold freezes the count.
// Ports:   clk, rst_n (async active-low), inc, clr, hold, count[CNT_W-1:0]
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             hold,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!hold && inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/perceptron_stimulus_driver.sv
// rtl/perceptron_stimulus_driver.sv - self-test stimulus front end of the classifier
// Purpose: accepts a digit request, drives its canonical features for a settle
//          window, samples the classifier answer and reports match/mismatch
//          with saturating pass/fail tallies.
// Ports:   clk, rst_n (async active-low), ena
//          req_valid, req_digit[3:0], req_ready
//          feat_edges[2:0], feat_curves[3:0], feat_valid, cls_out[3:0]
//          rsp_valid, rsp_match, rsp_bad, rsp_got[3:0]
//          clear_cnt, pass_cnt[CNT_W-1:0], fail_cnt[CNT_W-1:0]
module perceptron_stimulus_driver
  import perceptron_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               req_valid,
  input  logic [DIGIT_W-1:0] req_digit,
  output logic               req_ready,
  output logic [EDGE_W-1:0]  feat_edges,
  output logic [CURVE_W-1:0] feat_curves,
  output logic               feat_valid,
  input  logic [DIGIT_W-1:0] cls_out,
  output logic               rsp_valid,
  output logic               rsp_match,
  output logic               rsp_bad,
  output logic [DIGIT_W-1:0] rsp_got,
  input  logic               clear_cnt,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt
);

  state_t             state_q, state_d;
  logic [3:0]         settle_q;
  logic [DIGIT_W-1:0] digit_q;
  feature_t           feat_q;
  logic               accept;
  logic               req_ok;

  assign req_ready = ena && (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign req_ok    = digit_ok(req_digit);

  // Gating with ena keeps the pulse to exactly one enabled cycle even if the
  // driver is frozen while sitting in REPORT.
  assign rsp_valid = ena && (state_q == ST_REPORT);

  assign feat_edges  = feat_q.edges;
  assign feat_curves = feat_q.curves;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ena) begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = req_ok ? ST_DRIVE : ST_REPORT;
          end
        end
        ST_DRIVE: begin
          if (settle_q == 4'd0) begin
            state_d = ST_SAMPLE;
          end
        end
        ST_SAMPLE: state_d = ST_REPORT;
        ST_REPORT: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q   <= 4'd0;
      digit_q    <= '0;
      feat_q     <= '0;
      feat_valid <= 1'b0;
      rsp_match  <= 1'b0;
      rsp_bad    <= 1'b0;
      rsp_got    <= '0;
    end else if (ena) begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            digit_q <= req_digit;
            if (req_ok) begin
              feat_q     <= feature_of(req_digit);
              feat_valid <= 1'b1;
              // DRIVE lasts SETTLE_CYCLES cycles, leaving at count zero.
              settle_q   <= 4'(SETTLE_CYCLES - 1);
            end else begin
              rsp_match <= 1'b0;
              rsp_bad   <= 1'b1;
              rsp_got   <= '0;
            end
          end
        end
        ST_DRIVE: begin
          if (settle_q != 4'd0) begin
            settle_q <= settle_q - 4'd1;
          end
        end
        ST_SAMPLE: begin
          rsp_got    <= cls_out;
          rsp_match  <= (cls_out == digit_q);
          rsp_bad    <= 1'b0;
          feat_q     <= '0;
          feat_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rsp_valid && rsp_match && !rsp_bad),
    .clr   (clear_cnt),
    .hold  (!ena),
    .count (pass_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rsp_valid && !rsp_match && !rsp_bad),
    .clr   (clear_cnt),
    .hold  (!ena),
    .count (fail_cnt)
  );

endmodule
